// File: rtl/move_sequencer_if.sv
// move_sequencer_if
//   Bundles the move-sequencer control inputs and the move outputs that
//   drive the 4x4 cell array select logic.
//   Parameter DEPTH sizes the history-depth field (log2(DEPTH)+1 bits).
//   Modports:
//     slave  - the sequencer: takes requests/user moves/random bits,
//              drives fire, x_nRow, row_column, add_n, busy, done,
//              depth, overflow.
//     master - the controlling side (user controls, random source and
//              cell array): the mirror image of slave.
interface move_sequencer_if #(
    parameter int DEPTH = 32
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          start_scramble;
    logic          start_solve;
    logic [2:0]    rand_in;
    logic          user_fire;
    logic          user_nRow;
    logic [3:0]    user_row_column;
    logic          user_error;

    logic          fire;
    logic          x_nRow;
    logic [3:0]    row_column;
    logic          add_n;
    logic          busy;
    logic          done;
    logic [DW-1:0] depth;
    logic          overflow;

    modport slave (
        input  start_scramble, start_solve, rand_in,
        input  user_fire, user_nRow, user_row_column, user_error,
        output fire, x_nRow, row_column, add_n,
        output busy, done, depth, overflow
    );

    modport master (
        output start_scramble, start_solve, rand_in,
        output user_fire, user_nRow, user_row_column, user_error,
        input  fire, x_nRow, row_column, add_n,
        input  busy, done, depth, overflow
    );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer
//   Registered move source for the 4x4 cell array. Three modes:
//     - pass-through of user moves (IDLE),
//     - paced random scramble of MOVES moves, GAP idle cycles apart,
//     - automatic solve replaying the move history in reverse with the
//       direction (add_n) inverted.
//   Every issued move is pushed onto a DEPTH-entry LIFO; when the LIFO is
//   full the move is still fired but not recorded, and overflow sticks.
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high; clears all state
//     bus   - move_sequencer_if.slave (requests in, registered moves out)
//   Parameters: MOVES (1..255), GAP (0..255), DEPTH (power of two, >= 2).
module move_sequencer #(
    parameter int MOVES = 16,
    parameter int GAP   = 15,
    parameter int DEPTH = 32
) (
    input logic               clk,
    input logic               reset,
    move_sequencer_if.slave   bus
);
    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    FULL   = DEPTH[AW:0];
    localparam logic [7:0]     GAP_L  = GAP[7:0];
    localparam logic [7:0]     MOVE_L = MOVES[7:0];

    typedef enum logic [2:0] {
        IDLE,
        SCR_WAIT,
        SCR_FIRE,
        SOL_WAIT,
        SOL_FIRE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  moves_q, moves_d;
    logic        fire_q, fire_d;
    logic        x_nrow_q, x_nrow_d;
    logic [3:0]  rc_q, rc_d;
    logic        add_n_q, add_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        finish_q, finish_d;     // last fire issued; done/busy drop next cycle
    logic [AW:0] depth_q, depth_d;
    logic        overflow_q, overflow_d;

    // History entry: {nRow, idx[1:0], add_n}
    logic [3:0]  hist [DEPTH];
    logic        push;
    logic        pop;
    logic [3:0]  push_entry;
    logic [AW:0] top_idx;
    logic [3:0]  top_entry;

    assign top_idx   = depth_q - 1'b1;
    assign top_entry = hist[top_idx[AW-1:0]];

    // One-hot to binary index; input is known one-hot when user_error is low.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        if (oh[3]) idx = 2'd3;
        return idx;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d    = state_q;
        gap_d      = gap_q;
        moves_d    = moves_q;
        fire_d     = 1'b0;
        x_nrow_d   = x_nrow_q;
        rc_d       = rc_q;
        add_n_d    = add_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        finish_d   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        push_entry = 4'd0;

        case (state_q)
            IDLE: begin
                if (finish_q) begin
                    // Cycle after the final generated fire: inputs still
                    // ignored because busy is high.
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (bus.start_scramble) begin
                    state_d = SCR_WAIT;
                    gap_d   = GAP_L;
                    moves_d = MOVE_L;
                    busy_d  = 1'b1;
                end else if (bus.start_solve) begin
                    if (depth_q != '0) begin
                        state_d = SOL_WAIT;
                        gap_d   = GAP_L;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.user_fire && !bus.user_error) begin
                    fire_d     = 1'b1;
                    x_nrow_d   = bus.user_nRow;
                    rc_d       = bus.user_row_column;
                    add_n_d    = 1'b0;
                    push       = 1'b1;
                    push_entry = {bus.user_nRow, onehot_to_idx(bus.user_row_column), 1'b0};
                end
            end

            SCR_WAIT: begin
                if (gap_q == 8'd0) state_d = SCR_FIRE;
                else               gap_d   = gap_q - 8'd1;
            end

            SCR_FIRE: begin
                fire_d     = 1'b1;
                x_nrow_d   = bus.rand_in[2];
                rc_d       = 4'b0001 << bus.rand_in[1:0];
                add_n_d    = 1'b0;
                push       = 1'b1;
                push_entry = {bus.rand_in, 1'b0};
                moves_d    = moves_q - 8'd1;
                if (moves_q <= 8'd1) begin
                    state_d  = IDLE;
                    finish_d = 1'b1;
                end else begin
                    state_d = SCR_WAIT;
                    gap_d   = GAP_L;
                end
            end

            SOL_WAIT: begin
                if (gap_q == 8'd0) state_d = SOL_FIRE;
                else               gap_d   = gap_q - 8'd1;
            end

            SOL_FIRE: begin
                fire_d   = 1'b1;
                pop      = 1'b1;
                x_nrow_d = top_entry[3];
                rc_d     = 4'b0001 << top_entry[2:1];
                add_n_d  = ~top_entry[0];
                if (depth_q <= 1) begin
                    state_d  = IDLE;
                    finish_d = 1'b1;
                end else begin
                    state_d = SOL_WAIT;
                    gap_d   = GAP_L;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // History occupancy: a push into a full LIFO is dropped and flagged.
    always_comb begin
        depth_d    = depth_q;
        overflow_d = overflow_q;
        if (push) begin
            if (depth_q == FULL) overflow_d = 1'b1;
            else                 depth_d    = depth_q + 1'b1;
        end else if (pop && depth_q != '0) begin
            depth_d = depth_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_q      <= 8'd0;
            moves_q    <= 8'd0;
            fire_q     <= 1'b0;
            x_nrow_q   <= 1'b0;
            rc_q       <= 4'd0;
            add_n_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            finish_q   <= 1'b0;
            depth_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            moves_q    <= moves_d;
            fire_q     <= fire_d;
            x_nrow_q   <= x_nrow_d;
            rc_q       <= rc_d;
            add_n_q    <= add_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            finish_q   <= finish_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the history array has no reset; depth_q = 0 already marks it
    // empty, and leaving it unreset lets it map onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (push && depth_q != FULL) hist[depth_q[AW-1:0]] <= push_entry;
    end

    assign bus.fire       = fire_q;
    assign bus.x_nRow     = x_nrow_q;
    assign bus.row_column = rc_q;
    assign bus.add_n      = add_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.depth      = depth_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
//   Directed stimulus with a scoreboard: each stimulus step pushes the
//   expected moves (fields + cycle of appearance) and expected done
//   pulses; a negedge monitor pops and compares whenever fire/done is high.
module tb_move_sequencer;
    localparam int MOVES = 4;
    localparam int GAP   = 3;
    localparam int DEPTH = 32;
    localparam int SP    = GAP + 2;   // fire spacing

    typedef struct {
        logic       x;
        logic [3:0] rc;
        logic       a;
        int         cyc;
    } exp_move_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   fails = 0;

    exp_move_t exp_q[$];
    int        done_q[$];

    move_sequencer_if #(.DEPTH(DEPTH)) bus ();

    move_sequencer #(.MOVES(MOVES), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented fire/done against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fire) begin
                check("fire_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_move_t e;
                    e = exp_q.pop_front();
                    check("fire_fields", {bus.x_nRow, bus.row_column, bus.add_n}, {e.x, e.rc, e.a});
                    check("fire_cycle", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
                check("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    task automatic push_move(input logic x, input logic [3:0] rc, input logic a, input int c);
        exp_move_t e;
        e.x = x; e.rc = rc; e.a = a; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // User move; fire appears after the sampling edge.
    task automatic user_move(input logic nrow, input logic [3:0] rc, input logic err, input bit expect_fire);
        @(negedge clk);
        bus.user_fire       = 1'b1;
        bus.user_nRow       = nrow;
        bus.user_row_column = rc;
        bus.user_error      = err;
        if (expect_fire) push_move(nrow, rc, 1'b0, cyc + 1);
        @(negedge clk);
        bus.user_fire  = 1'b0;
        bus.user_error = 1'b0;
    endtask

    // Raise a start request at a negedge; s is the cycle count of the
    // sampling edge. The caller pushes expectations, then calls end_start.
    task automatic begin_start(input bit scramble, output int s);
        @(negedge clk);
        if (scramble) bus.start_scramble = 1'b1;
        else          bus.start_solve    = 1'b1;
        s = cyc + 1;
    endtask

    task automatic end_start();
        @(negedge clk);
        bus.start_scramble = 1'b0;
        bus.start_solve    = 1'b0;
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || done_q.size() != 0); i++)
            @(negedge clk);
        @(negedge clk);
        check(name, exp_q.size() + done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        int s;
        bus.start_scramble  = 1'b0;
        bus.start_solve     = 1'b0;
        bus.rand_in         = 3'b000;
        bus.user_fire       = 1'b0;
        bus.user_nRow       = 1'b0;
        bus.user_row_column = 4'b0000;
        bus.user_error      = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.fire, bus.x_nRow, bus.row_column, bus.add_n, bus.busy, bus.done, bus.overflow},
              10'd0);
        check("reset_depth", bus.depth, 0);
        reset = 1'b0;

        // Single user move, then an erroneous one that must be dropped
        user_move(1'b0, 4'b0100, 1'b0, 1'b1);
        drain("user_drain");
        check("user_depth", bus.depth, 1);
        user_move(1'b0, 4'b0011, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("error_depth", bus.depth, 1);

        // Scramble: 4 moves with rand_in = 110 -> column, 0100
        do_reset();
        bus.rand_in = 3'b110;
        begin_start(1'b1, s);
        for (int k = 1; k <= MOVES; k++) push_move(1'b1, 4'b0100, 1'b0, s + k * SP);
        done_q.push_back(s + MOVES * SP + 1);
        end_start();
        repeat (2) @(negedge clk);
        check("scr_busy", bus.busy, 1'b1);
        user_move(1'b1, 4'b0001, 1'b0, 1'b0);       // ignored while busy
        begin_start(1'b0, s);                        // ignored while busy
        end_start();
        drain("scr_drain");
        check("scr_depth", bus.depth, MOVES);
        check("scr_hold", {bus.x_nRow, bus.row_column, bus.add_n}, 6'b1_0100_0);
        check("scr_overflow", bus.overflow, 1'b0);

        // Solve: history row0, col2, row3 replayed reversed with add_n=1
        do_reset();
        user_move(1'b0, 4'b0001, 1'b0, 1'b1);
        user_move(1'b1, 4'b0100, 1'b0, 1'b1);
        user_move(1'b0, 4'b1000, 1'b0, 1'b1);
        drain("hist_drain");
        check("hist_depth", bus.depth, 3);
        begin_start(1'b0, s);
        push_move(1'b0, 4'b1000, 1'b1, s + 1 * SP);
        push_move(1'b1, 4'b0100, 1'b1, s + 2 * SP);
        push_move(1'b0, 4'b0001, 1'b1, s + 3 * SP);
        done_q.push_back(s + 3 * SP + 1);
        end_start();
        drain("sol_drain");
        check("sol_depth", bus.depth, 0);
        check("sol_hold", {bus.x_nRow, bus.row_column, bus.add_n}, 6'b0_0001_1);

        // Solve with empty history: immediate done, no fires, never busy
        begin_start(1'b0, s);
        done_q.push_back(s);
        end_start();
        check("empty_busy", bus.busy, 1'b0);
        drain("empty_drain");

        // Overflow: 33 user moves, all fired, 32 recorded
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (i % 4);
            user_move(1'(i % 2), oh, 1'b0, 1'b1);
        end
        drain("ovf_drain");
        check("ovf_depth", bus.depth, DEPTH);
        check("ovf_flag", bus.overflow, 1'b1);

        // Reset in the second scramble gap
        do_reset();
        check("rst_clear_overflow", bus.overflow, 1'b0);
        bus.rand_in = 3'b111;
        begin_start(1'b1, s);
        push_move(1'b1, 4'b1000, 1'b0, s + SP);
        end_start();
        for (int i = 0; i < 50 && cyc < s + SP + 2; i++) @(negedge clk);
        check("mid_depth", bus.depth, 1);
        check("mid_busy", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_outputs",
              {bus.fire, bus.x_nRow, bus.row_column, bus.add_n, bus.busy, bus.done, bus.overflow},
              10'd0);
        check("async_depth", bus.depth, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);         // monitor flags any stray fire/done
        check("post_reset_queue", exp_q.size() + done_q.size(), 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
